// File: rtl/ysyx_22050133_stage_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with variable-latency waits, ebreak halt and per-stage watchdog.
// Optional performance counters are built when YSYX_22050133_PERF_CNT_EN is defined.
module ysyx_22050133_stage_ctrl #(
    parameter int unsigned WDT_CYCLES = 1023,
    parameter int unsigned CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifu_valid,
    input  logic             exu_multi,
    input  logic             exu_done,
    input  logic             mem_need,
    input  logic             lsu_done,
    input  logic             lsu_err,
    input  logic             halt_req,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             ifu_req,
    output logic             exu_start,
    output logic             lsu_start,
    output logic             instret,
    output logic             halted,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stl_cnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LSU  = 2'd1;
    localparam logic [1:0] ERR_WDT  = 2'd2;

    // The counter only has to hold WDT_CYCLES-1: the cycle it would reach WDT_CYCLES is the timeout.
    localparam int unsigned         WDT_W    = (WDT_CYCLES < 2) ? 1 : $clog2(WDT_CYCLES);
    localparam bit                  WDT_EN   = (WDT_CYCLES != 0);
    localparam logic [WDT_W-1:0]    WDT_LAST = WDT_W'((WDT_CYCLES == 0) ? 0 : WDT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             entry_q;
    logic             multi_q, multi_d;
    logic             mem_q, mem_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             waiting;
    logic             wdt_fire;
    logic             run;

    assign run      = ~rst;
    assign wdt_fire = WDT_EN && (wdt_q == WDT_LAST);

    always_comb begin
        state_d = state_q;
        multi_d = multi_q;
        mem_d   = mem_q;
        err_d   = err_q;
        code_d  = code_q;
        waiting = 1'b0;
        case (state_q)
            S_IF: begin
                waiting = 1'b1;
                if (ifu_valid) begin
                    state_d = S_ID;
                end else if (wdt_fire) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                    code_d  = ERR_WDT;
                end
            end
            S_ID: begin
                multi_d = exu_multi;
                mem_d   = mem_need;
                state_d = S_EX;
            end
            S_EX: begin
                waiting = 1'b1;
                if (!multi_q || exu_done) begin
                    state_d = mem_q ? S_MEM : S_WB;
                end else if (wdt_fire) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                    code_d  = ERR_WDT;
                end
            end
            S_MEM: begin
                waiting = 1'b1;
                if (lsu_done) begin
                    if (lsu_err) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                        code_d  = ERR_LSU;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wdt_fire) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                    code_d  = ERR_WDT;
                end
            end
            S_WB: begin
                state_d = halt_req ? S_HALT : S_IF;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Corrupted state register: stop and report it like a hang.
                state_d = S_HALT;
                err_d   = 1'b1;
                code_d  = ERR_WDT;
            end
        endcase

        if (state_d != state_q) begin
            wdt_d = '0;
        end else if (waiting) begin
            wdt_d = wdt_q + WDT_W'(1);
        end else begin
            wdt_d = wdt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            entry_q <= 1'b1;
            multi_q <= 1'b0;
            mem_q   <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            wdt_q   <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= (state_d != state_q);
            multi_q <= multi_d;
            mem_q   <= mem_d;
            err_q   <= err_d;
            code_q  <= code_d;
            wdt_q   <= wdt_d;
        end
    end

    // Everything below decodes registered state only, gated off while reset is held.
    assign if_en     = run && (state_q == S_IF);
    assign id_en     = run && (state_q == S_ID);
    assign ex_en     = run && (state_q == S_EX);
    assign mem_en    = run && (state_q == S_MEM);
    assign wb_en     = run && (state_q == S_WB);
    assign ifu_req   = if_en  && entry_q;
    assign exu_start = ex_en  && entry_q;
    assign lsu_start = mem_en && entry_q;
    assign instret   = wb_en;
    assign halted    = run && (state_q == S_HALT);
    assign err       = run && err_q;
    assign err_code  = run ? code_q : ERR_NONE;
    assign state     = run ? state_q : 3'd0;

`ifdef YSYX_22050133_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q, stl_q;
    logic             stall;

    assign stall = !entry_q && ((state_q == S_IF) || (state_q == S_EX) || (state_q == S_MEM));

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
            stl_q <= '0;
        end else begin
            if (state_q != S_HALT) begin
                cyc_q <= cyc_q + CNT_W'(1);
            end
            if (state_q == S_WB) begin
                ret_q <= ret_q + CNT_W'(1);
            end
            if (stall) begin
                stl_q <= stl_q + CNT_W'(1);
            end
        end
    end

    assign cyc_cnt = run ? cyc_q : '0;
    assign ret_cnt = run ? ret_q : '0;
    assign stl_cnt = run ? stl_q : '0;
`else
    assign cyc_cnt = '0;
    assign ret_cnt = '0;
    assign stl_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050133_stage_ctrl.sv
// Scoreboard bench for ysyx_22050133_stage_ctrl: per-cycle expectations are queued by the driver
// and compared by a negedge monitor. Instance b uses a short watchdog.
module tb_ysyx_22050133_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic ifu_valid = 1'b0, exu_multi = 1'b0, exu_done = 1'b0, mem_need = 1'b0;
    logic lsu_done = 1'b0, lsu_err = 1'b0, halt_req = 1'b0;

    logic a_if, a_id, a_ex, a_mem, a_wb, a_ifu_req, a_exu_start, a_lsu_start, a_instret, a_halted, a_err;
    logic [1:0]  a_code;
    logic [2:0]  a_state;
    logic [63:0] a_cyc, a_ret, a_stl;
    logic b_if, b_id, b_ex, b_mem, b_wb, b_ifu_req, b_exu_start, b_lsu_start, b_instret, b_halted, b_err;
    logic [1:0]  b_code;
    logic [2:0]  b_state;
    logic [63:0] b_cyc, b_ret, b_stl;

    ysyx_22050133_stage_ctrl #(.WDT_CYCLES(1023), .CNT_W(64)) dut_a (
        .clk(clk), .rst(rst), .ifu_valid(ifu_valid), .exu_multi(exu_multi), .exu_done(exu_done),
        .mem_need(mem_need), .lsu_done(lsu_done), .lsu_err(lsu_err), .halt_req(halt_req),
        .if_en(a_if), .id_en(a_id), .ex_en(a_ex), .mem_en(a_mem), .wb_en(a_wb),
        .ifu_req(a_ifu_req), .exu_start(a_exu_start), .lsu_start(a_lsu_start), .instret(a_instret),
        .halted(a_halted), .err(a_err), .err_code(a_code), .state(a_state),
        .cyc_cnt(a_cyc), .ret_cnt(a_ret), .stl_cnt(a_stl)
    );

    ysyx_22050133_stage_ctrl #(.WDT_CYCLES(8), .CNT_W(64)) dut_b (
        .clk(clk), .rst(rst), .ifu_valid(ifu_valid), .exu_multi(exu_multi), .exu_done(exu_done),
        .mem_need(mem_need), .lsu_done(lsu_done), .lsu_err(lsu_err), .halt_req(halt_req),
        .if_en(b_if), .id_en(b_id), .ex_en(b_ex), .mem_en(b_mem), .wb_en(b_wb),
        .ifu_req(b_ifu_req), .exu_start(b_exu_start), .lsu_start(b_lsu_start), .instret(b_instret),
        .halted(b_halted), .err(b_err), .err_code(b_code), .state(b_state),
        .cyc_cnt(b_cyc), .ret_cnt(b_ret), .stl_cnt(b_stl)
    );

    wire [15:0] obs_a = {a_state, a_if, a_id, a_ex, a_mem, a_wb,
                         a_ifu_req, a_exu_start, a_lsu_start, a_instret, a_halted, a_err, a_code};
    wire [15:0] obs_b = {b_state, b_if, b_id, b_ex, b_mem, b_wb,
                         b_ifu_req, b_exu_start, b_lsu_start, b_instret, b_halted, b_err, b_code};

`ifdef YSYX_22050133_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Input word: {rst, ifu_valid, exu_multi, exu_done, mem_need, lsu_done, lsu_err, halt_req}
    localparam logic [7:0] R  = 8'h80, IV = 8'h40, EM = 8'h20, ED = 8'h10;
    localparam logic [7:0] MN = 8'h08, LD = 8'h04, LE = 8'h02, HR = 8'h01;

    typedef struct {
        bit          which;
        bit          r;
        int          st;
        bit          ent;
        bit          er;
        logic [1:0]  code;
        logic [63:0] cyc;
        logic [63:0] ret;
        logic [63:0] stl;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_txn = 0;
    bit          use_w = 1'b0;
    bit          x_err = 1'b0;
    logic [1:0]  x_code = 2'd0;
    logic [63:0] e_cyc = 64'd0, e_ret = 64'd0, e_stl = 64'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    // One clock cycle: inputs applied for this cycle, plus the outputs expected during it.
    task automatic tick(input logic [7:0] in, input int st, input bit ent);
        exp_t e;
        @(posedge clk);
        #1;
        {rst, ifu_valid, exu_multi, exu_done, mem_need, lsu_done, lsu_err, halt_req} = in;
        e.which = use_w;
        e.r     = in[7];
        e.st    = st;
        e.ent   = ent;
        e.er    = x_err;
        e.code  = x_code;
        e.cyc   = PERF ? e_cyc : 64'd0;
        e.ret   = PERF ? e_ret : 64'd0;
        e.stl   = PERF ? e_stl : 64'd0;
        sb.push_back(e);
        if (in[7]) begin
            e_cyc = 64'd0;
            e_ret = 64'd0;
            e_stl = 64'd0;
        end else begin
            if (st != 5) e_cyc++;
            if (st == 4) e_ret++;
            if (!ent && (st == 0 || st == 2 || st == 3)) e_stl++;
        end
    endtask

    exp_t        m_e;
    logic [15:0] m_got, m_want;
    logic [4:0]  m_en;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_e   = sb.pop_front();
            m_got = m_e.which ? obs_b : obs_a;
            if (m_e.r) begin
                m_want = 16'd0;
            end else begin
                m_en   = (m_e.st < 5) ? (5'b10000 >> m_e.st) : 5'b00000;
                m_want = {3'(m_e.st), m_en,
                          (m_e.ent && m_e.st == 0), (m_e.ent && m_e.st == 2),
                          (m_e.ent && m_e.st == 3), (m_e.st == 4),
                          (m_e.st == 5), m_e.er, m_e.code};
            end
            n_txn++;
            $display("txn %0d dut_%s rst=%0b state=%0d want=%0d", n_txn, m_e.which ? "b" : "a",
                     m_e.r, m_got[15:13], m_want[15:13]);
            chk("state",    64'(m_got[15:13]), 64'(m_want[15:13]));
            chk("enables",  64'(m_got[12:8]),  64'(m_want[12:8]));
            chk("pulses",   64'(m_got[7:4]),   64'(m_want[7:4]));
            chk("halted",   64'(m_got[3]),     64'(m_want[3]));
            chk("err",      64'(m_got[2]),     64'(m_want[2]));
            chk("err_code", 64'(m_got[1:0]),   64'(m_want[1:0]));
            chk("cyc_cnt", m_e.which ? b_cyc : a_cyc, m_e.r ? 64'd0 : m_e.cyc);
            chk("ret_cnt", m_e.which ? b_ret : a_ret, m_e.r ? 64'd0 : m_e.ret);
            chk("stl_cnt", m_e.which ? b_stl : a_stl, m_e.r ? 64'd0 : m_e.stl);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        tick(R, 0, 0); tick(R, 0, 0);
        // Back-to-back ALU op, ifu_valid held high
        tick(IV, 0, 1); tick(IV, 1, 1); tick(IV, 2, 1); tick(IV, 4, 1);
        // Memory op, lsu_done 3 cycles after lsu_start; stray lsu_done in EX ignored
        tick(IV, 0, 1); tick(MN, 1, 1); tick(LD, 2, 1);
        tick(0, 3, 1); tick(0, 3, 0); tick(0, 3, 0); tick(LD, 3, 0); tick(0, 4, 1);
        // Multi-cycle op done in start cycle; halt_req outside WB ignored
        tick(IV, 0, 1); tick(EM, 1, 1); tick(ED | HR, 2, 1); tick(0, 4, 1);
        // Fetch stall, stray exu_done in ID, EX waits 11 cycles
        tick(0, 0, 1); tick(0, 0, 0); tick(IV, 0, 0); tick(EM | ED, 1, 1); tick(0, 2, 1);
        for (int i = 0; i < 9; i++) tick(0, 2, 0);
        tick(ED, 2, 0); tick(0, 4, 1);
        // Multi-cycle op with memory, lsu_done in MEM entry cycle
        tick(IV, 0, 1); tick(EM | MN, 1, 1); tick(0, 2, 1); tick(ED, 2, 0); tick(LD, 3, 1); tick(0, 4, 1);
        // LSU fault: halt without instret, inputs ignored afterwards
        tick(IV, 0, 1); tick(MN, 1, 1); tick(0, 2, 1); tick(0, 3, 1); tick(LD | LE, 3, 0);
        x_err = 1'b1; x_code = 2'd1;
        tick(IV | HR, 5, 1); tick(IV | LD | ED, 5, 0); tick(IV, 5, 0);
        // ebreak halt: clean stop, cyc_cnt frozen
        tick(R, 0, 0);
        x_err = 1'b0; x_code = 2'd0;
        tick(IV, 0, 1); tick(0, 1, 1); tick(HR, 2, 1); tick(HR, 4, 1);
        tick(IV, 5, 1); tick(IV, 5, 0); tick(0, 5, 0);
        // Reset asserted mid-MEM
        tick(R, 0, 0);
        tick(IV, 0, 1); tick(MN, 1, 1); tick(0, 2, 1); tick(0, 3, 1); tick(0, 3, 0);
        tick(R | LD, 0, 0);
        tick(IV, 0, 1); tick(0, 1, 1); tick(0, 2, 1); tick(0, 4, 1);
        // Short watchdog instance: IF timeout
        use_w = 1'b1;
        tick(R, 0, 0);
        tick(0, 0, 1);
        for (int i = 0; i < 7; i++) tick(0, 0, 0);
        x_err = 1'b1; x_code = 2'd2;
        tick(IV, 5, 1); tick(IV, 5, 0);
        // ifu_valid in the timeout cycle wins
        tick(R, 0, 0);
        x_err = 1'b0; x_code = 2'd0;
        tick(0, 0, 1);
        for (int i = 0; i < 6; i++) tick(0, 0, 0);
        tick(IV, 0, 0); tick(0, 1, 1); tick(0, 2, 1); tick(0, 4, 1);
        // MEM timeout
        tick(IV, 0, 1); tick(MN, 1, 1); tick(0, 2, 1); tick(0, 3, 1);
        for (int i = 0; i < 7; i++) tick(0, 3, 0);
        x_err = 1'b1; x_code = 2'd2;
        tick(IV, 5, 1); tick(0, 5, 0);

        @(negedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
